mmu_ctxload: RTL and testbench

- Context-switch sequencer for the MMU page table.
- Holds NCTX shadow page-table contexts (8 PTEs each) in kernel-accessible I/O space at $FEDx.
- On command, streams one context into the live page table: one PTE per E-clock over 8 cycles.
- Lets the kernel switch process address spaces with a single register write instead of 8 stores.

---
 rtl/mmu_ctxload.sv | 132 +++++++++++++
 tb/tb_mmu_ctxload.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_ctxload.sv
// Context-switch sequencer: holds NCTX shadow page-table contexts and streams one into the live
// MMU page table, one PTE per E-clock. Define MMU_CTXLOAD_IRQ_EN to drive the completion interrupt.
module mmu_ctxload #(
   parameter int NCTX_BITS = 2
) (
   input  logic       i_eclk,
   input  logic       i_reset_n,
   input  logic       i_cs,
   input  logic       i_rw,
   input  logic [3:0] i_addr,
   input  logic [7:0] i_data,
   output logic [7:0] o_data,
   output logic       o_ptwe,
   output logic [2:0] o_ptidx,
   output logic [7:0] o_ptdata,
   output logic       o_busy,
   output logic       o_irq_n
);

   localparam int NCTX = 1 << NCTX_BITS;

   typedef enum logic {
      IDLE = 1'b0,
      COPY = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [7:0]           store [NCTX*8];
   logic [NCTX_BITS-1:0] ctxsel;
   logic [NCTX_BITS-1:0] src;
   logic [NCTX_BITS-1:0] live;
   logic [3:0]           cnt;
   logic                 err;
   logic                 done;

   logic wr, rd;
   logic wr_entry, wr_ctxsel, wr_load, rd_status;
   logic busy, entry_blocked, load_go, copy_end;
   logic [7:0] status;

   assign wr        = i_cs & ~i_rw;
   assign rd        = i_cs & i_rw;
   assign wr_entry  = wr & ~i_addr[3];
   assign wr_ctxsel = wr & (i_addr == 4'h8);
   assign wr_load   = wr & (i_addr == 4'h9);
   assign rd_status = rd & (i_addr == 4'hA);

   assign busy          = (state == COPY);
   // The context being streamed is frozen for the whole copy window.
   assign entry_blocked = busy & (ctxsel == src);
   assign load_go       = wr_load & ~busy;
   // cnt reaches 8 on the edge after the last PTE write; that edge closes the copy.
   assign copy_end      = busy & (cnt == 4'd8);

   assign status = 8'(live) | {busy, err, done, 5'b00000};

   always_ff @(posedge i_eclk or negedge i_reset_n) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_go)  state_nxt = COPY;
         COPY:    if (copy_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_eclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ctxsel   <= '0;
         src      <= '0;
         live     <= '0;
         cnt      <= 4'd0;
         err      <= 1'b0;
         done     <= 1'b0;
         o_ptwe   <= 1'b0;
         o_ptidx  <= 3'd0;
         o_ptdata <= 8'h00;
      end else begin
         if (wr_ctxsel) ctxsel <= i_data[NCTX_BITS-1:0];

         if (load_go) begin
            src <= i_data[NCTX_BITS-1:0];
            cnt <= 4'd0;
         end

         if (busy && !copy_end) begin
            o_ptwe   <= 1'b1;
            o_ptidx  <= cnt[2:0];
            o_ptdata <= store[{src, cnt[2:0]}];
            cnt      <= cnt + 4'd1;
         end else begin
            o_ptwe <= 1'b0;
         end

         if (copy_end) live <= src;

         // Setting has priority over the clear-on-read of STATUS.
         if ((wr_load && busy) || (wr_entry && entry_blocked)) err <= 1'b1;
         else if (rd_status)                                   err <= 1'b0;

         if (copy_end)                  done <= 1'b1;
         else if (load_go || rd_status) done <= 1'b0;
      end
   end

   always_ff @(posedge i_eclk) begin
      if (wr_entry && !entry_blocked) store[{ctxsel, i_addr[2:0]}] <= i_data;
   end

   always_comb begin
      o_data = 8'h00;
      if (i_cs) begin
         if (!i_addr[3])            o_data = store[{ctxsel, i_addr[2:0]}];
         else if (i_addr == 4'h8)   o_data = 8'(ctxsel);
         else if (i_addr == 4'hA)   o_data = status;
      end
   end

   assign o_busy = busy;

`ifdef MMU_CTXLOAD_IRQ_EN
   assign o_irq_n = ~done;
`else
   assign o_irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_mmu_ctxload.sv
// Directed and randomized bench for mmu_ctxload with a register-level reference model
// and a monitor capturing every live page-table write.
module tb_mmu_ctxload;

   logic       i_eclk;
   logic       i_reset_n;
   logic       i_cs;
   logic       i_rw;
   logic [3:0] i_addr;
   logic [7:0] i_data;
   logic [7:0] o_data;
   logic       o_ptwe;
   logic [2:0] o_ptidx;
   logic [7:0] o_ptdata;
   logic       o_busy;
   logic       o_irq_n;

   mmu_ctxload #(.NCTX_BITS(2)) dut (
      .i_eclk    (i_eclk),
      .i_reset_n (i_reset_n),
      .i_cs      (i_cs),
      .i_rw      (i_rw),
      .i_addr    (i_addr),
      .i_data    (i_data),
      .o_data    (o_data),
      .o_ptwe    (o_ptwe),
      .o_ptidx   (o_ptidx),
      .o_ptdata  (o_ptdata),
      .o_busy    (o_busy),
      .o_irq_n   (o_irq_n)
   );

   initial i_eclk = 1'b0;
   always #5 i_eclk = ~i_eclk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int load_cyc = 0;
   int fall_cyc = 0;
   logic prev_busy = 1'b0;

   logic [10:0] got_q[$];
   int          gotc_q[$];
   logic [10:0] exp_q[$];

   // Reference model of the register file
   logic [7:0] m_store [32];
   logic [1:0] m_ctxsel, m_src, m_live;
   logic       m_err, m_done, m_busy;

   always @(posedge i_eclk) cyc <= cyc + 1;

   always @(posedge i_eclk) begin
      #1;
      if (o_ptwe) begin
         got_q.push_back({o_ptidx, o_ptdata});
         gotc_q.push_back(cyc);
      end
      if (prev_busy && !o_busy) fall_cyc = cyc;
      prev_busy = o_busy;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_status();
      return {m_busy, m_err, m_done, 3'b000, m_live};
   endfunction

   task automatic check_irq(input string tag);
`ifdef MMU_CTXLOAD_IRQ_EN
      check(tag, 32'(o_irq_n), 32'(!m_done));
`else
      check(tag, 32'(o_irq_n), 32'd1);
`endif
   endtask

   task automatic model_reset();
      m_ctxsel = 2'd0;
      m_src    = 2'd0;
      m_live   = 2'd0;
      m_err    = 1'b0;
      m_done   = 1'b0;
      m_busy   = 1'b0;
      got_q.delete();
      gotc_q.delete();
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_eclk);
      #2;
   endtask

   task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge i_eclk);
      i_cs = 1'b1; i_rw = 1'b0; i_addr = a; i_data = d;
      @(posedge i_eclk);
      #2;
      i_cs = 1'b0; i_rw = 1'b1;
      if (a < 4'h8) begin
         if (m_busy && m_ctxsel == m_src) m_err = 1'b1;
         else m_store[{m_ctxsel, a[2:0]}] = d;
      end else if (a == 4'h8) begin
         m_ctxsel = d[1:0];
      end else if (a == 4'h9) begin
         if (m_busy) m_err = 1'b1;
         else begin
            m_busy = 1'b1;
            m_src  = d[1:0];
            m_done = 1'b0;
            load_cyc = cyc;
            for (int e = 0; e < 8; e++) exp_q.push_back({3'(e), m_store[{m_src, 3'(e)}]});
         end
      end
   endtask

   task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
      @(negedge i_eclk);
      i_cs = 1'b1; i_rw = 1'b1; i_addr = a;
      #1 d = o_data;
      @(posedge i_eclk);
      #2;
      i_cs = 1'b0;
   endtask

   task automatic read_status(input string tag);
      logic [7:0] d;
      logic [7:0] e;
      e = m_status();
      cpu_read(4'hA, d);
      check(tag, 32'(d), 32'(e));
      m_err  = 1'b0;
      m_done = 1'b0;
      check_irq({tag, " irq"});
   endtask

   task automatic finish_copy(input string tag);
      int n;
      n = 0;
      while (o_busy && n < 30) begin
         @(posedge i_eclk);
         #2;
         n++;
      end
      check({tag, " busy drop"}, 32'(o_busy), 32'd0);
      check({tag, " latency"}, 32'(fall_cyc - load_cyc), 32'd9);
      check({tag, " write count"}, 32'(got_q.size()), 32'd8);
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s pte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
         check($sformatf("%s cyc%0d", tag, i), 32'(gotc_q[i] - load_cyc), 32'(i + 1));
      end
      m_busy = 1'b0;
      m_live = m_src;
      m_done = 1'b1;
      got_q.delete();
      gotc_q.delete();
      exp_q.delete();
      check_irq({tag, " irq"});
   endtask

   initial begin
      logic [7:0] d;
      logic [1:0] c;
      logic [2:0] e;

      i_reset_n = 1'b0; i_cs = 1'b0; i_rw = 1'b1; i_addr = 4'h0; i_data = 8'h00;
      model_reset();
      idle(3);
      @(negedge i_eclk);
      i_reset_n = 1'b1;
      #1;
      check("reset ptwe", 32'(o_ptwe), 32'd0);
      check("reset busy", 32'(o_busy), 32'd0);
      check("reset irq", 32'(o_irq_n), 32'd1);
      read_status("reset status");

      // Fill all contexts; context 2 gets a recognisable ramp
      for (int ci = 0; ci < 4; ci++) begin
         cpu_write(4'h8, 8'(ci));
         for (int ei = 0; ei < 8; ei++)
            cpu_write(4'(ei), (ci == 2) ? 8'(8'h10 + ei) : 8'($urandom_range(0, 255)));
      end
      for (int k = 0; k < 4; k++) begin
         c = 2'($urandom_range(0, 3));
         e = 3'($urandom_range(0, 7));
         cpu_write(4'h8, {6'b0, c});
         cpu_read({1'b0, e}, d);
         check($sformatf("readback ctx%0d e%0d", c, e), 32'(d), 32'(m_store[{c, e}]));
      end
      cpu_write(4'h8, 8'hFF);
      cpu_read(4'h8, d);
      check("ctxsel upper bits", 32'(d), 32'h03);
      cpu_read(4'h9, d);
      check("load reads zero", 32'(d), 32'h00);
      cpu_read(4'hC, d);
      check("unmapped reads zero", 32'(d), 32'h00);

      // Plain copy of context 2
      cpu_write(4'h8, 8'h02);
      cpu_write(4'h9, 8'h02);
      check("busy after load", 32'(o_busy), 32'd1);
      check("no ptwe on load edge", 32'(o_ptwe), 32'd0);
      finish_copy("copyA");
      read_status("copyA status");
      read_status("copyA status2");

      // Rejected LOAD and ENTRY-to-source writes during a copy
      cpu_write(4'h9, 8'h02);
      cpu_write(4'h9, 8'h01);
      cpu_write(4'h3, 8'hFF);
      finish_copy("copyB");
      read_status("copyB status err");
      read_status("copyB status cleared");

      // Writes to another context during a copy are accepted
      cpu_write(4'h9, 8'h02);
      cpu_write(4'h8, 8'h01);
      cpu_write(4'h0, 8'h85);
      cpu_read(4'h0, d);
      check("other ctx entry0", 32'(d), 32'h85);
      read_status("copyC mid status");
      finish_copy("copyC");
      read_status("copyC status");

      // STATUS read on the very edge that sets DONE: DONE survives
      cpu_write(4'h9, 8'h00);
      idle(8);
      cpu_read(4'hA, d);
      check("coincident status", 32'(d), 32'(8'h80 | 8'(m_live)));
      finish_copy("copyD");
      read_status("copyD done kept");

      // Randomised edits and loads
      for (int r = 0; r < 4; r++) begin
         c = 2'($urandom_range(0, 3));
         e = 3'($urandom_range(0, 7));
         cpu_write(4'h8, {6'b0, c});
         cpu_write({1'b0, e}, 8'($urandom_range(0, 255)));
         cpu_write(4'h9, 8'($urandom_range(0, 3)));
         finish_copy($sformatf("rand%0d", r));
         read_status($sformatf("rand%0d status", r));
      end

      // Reset in the middle of a copy
      cpu_write(4'h8, 8'h03);
      cpu_write(4'h9, 8'h03);
      idle(3);
      check("midreset ptwe before", 32'(o_ptwe), 32'd1);
      check("midreset writes before", 32'(got_q.size()), 32'd3);
      i_reset_n = 1'b0;
      #1;
      check("midreset ptwe async", 32'(o_ptwe), 32'd0);
      check("midreset busy async", 32'(o_busy), 32'd0);
      check("midreset irq", 32'(o_irq_n), 32'd1);
      for (int i = 0; i < 3 && i < got_q.size(); i++)
         check($sformatf("midreset pte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      @(negedge i_eclk);
      i_reset_n = 1'b1;
      idle(12);
      check("midreset no more writes", 32'(got_q.size()), 32'd3);
      model_reset();
      read_status("midreset status");
      cpu_read(4'h8, d);
      check("midreset ctxsel", 32'(d), 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
